// File: rtl/score_keeper_bcd.sv
// score_keeper_bcd: packed-BCD game score with timed and event points,
// a gameover freeze and a high-score register with a new-record flag.
//
// Ports:
//   clk, reset (async, active-low)
//   start, gameover, clear_hi         control pulses
//   add_valid, add_value[3:0]         event points (BCD, clamped to 9)
//   score, hi_score [4*NUM_DIGITS]    packed BCD, LS digit at [3:0]
//   running, new_hi, saturated        status flags
module score_keeper_bcd #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 100000000,
  parameter bit SIMULATE   = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    gameover,
  input  logic                    add_valid,
  input  logic [3:0]              add_value,
  input  logic                    clear_hi,
  output logic [4*NUM_DIGITS-1:0] score,
  output logic [4*NUM_DIGITS-1:0] hi_score,
  output logic                    running,
  output logic                    new_hi,
  output logic                    saturated
);

  localparam int DIV = SIMULATE ? 10 : TICK_DIV;
  localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int W   = 4 * NUM_DIGITS;
  localparam int XW  = W + 4;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [W-1:0]  ALL_NINE = {NUM_DIGITS{4'h9}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic          go_run;
  logic          end_game;
  logic [DW-1:0] div_cnt;
  logic          tick;

  logic [3:0]    pts;
  logic [3:0]    inc;
  logic          inc_hi;
  logic [3:0]    inc_lo;

  logic [XW-1:0] score_x;
  logic [XW-1:0] sum_x;
  logic [3:0]    dig_a;
  logic [3:0]    dig_b;
  logic [4:0]    dig_s;
  logic          cy;
  logic          ovf;

  // Next-state decode. gameover wins over start only in RUN,
  // where start is ignored anyway.
  always_comb begin
    state_nx = state;
    go_run   = 1'b0;
    end_game = 1'b0;
    unique case (1'b1)
      (state == RUN): begin
        if (gameover) begin
          state_nx = OVER;
          end_game = 1'b1;
        end
      end
      (state == IDLE),
      (state == OVER): begin
        if (start) begin
          state_nx = RUN;
          go_run   = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  assign tick = (state == RUN) && (div_cnt == DIV_LAST);

  // Increment is 0..10; split it into two BCD digits.
  always_comb begin
    pts = 4'd0;
    if (add_valid) begin
      pts = (add_value > 4'd9) ? 4'd9 : add_value;
    end
    inc    = pts + {3'b000, tick};
    inc_hi = (inc == 4'd10);
    inc_lo = inc_hi ? 4'd0 : inc;
  end

  // One spare digit on top catches overflow past NUM_DIGITS,
  // including a carry of 10 into a single-digit score.
  assign score_x = {4'h0, score};

  always_comb begin
    sum_x = '0;
    cy    = 1'b0;
    dig_a = 4'h0;
    dig_b = 4'h0;
    dig_s = 5'd0;
    for (int i = 0; i <= NUM_DIGITS; i++) begin
      dig_a = score_x[4*i +: 4];
      dig_b = 4'h0;
      if (i == 0) begin
        dig_b = inc_lo;
      end else if (i == 1) begin
        dig_b = {3'b000, inc_hi};
      end
      dig_s = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0000, cy};
      if (dig_s > 5'd9) begin
        sum_x[4*i +: 4] = 4'(dig_s - 5'd10);
        cy              = 1'b1;
      end else begin
        sum_x[4*i +: 4] = dig_s[3:0];
        cy              = 1'b0;
      end
    end
  end

  assign ovf = (sum_x[XW-1 -: 4] != 4'h0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      score     <= '0;
      hi_score  <= '0;
      div_cnt   <= '0;
      running   <= 1'b0;
      new_hi    <= 1'b0;
      saturated <= 1'b0;
    end else begin
      running <= (state_nx == RUN);
      if (go_run) begin
        score     <= '0;
        div_cnt   <= '0;
        saturated <= 1'b0;
        new_hi    <= 1'b0;
      end else if (end_game) begin
        // Valid BCD digits order the same as the binary
        // value of the packed vector.
        if (score > hi_score) begin
          hi_score <= score;
          new_hi   <= 1'b1;
        end else begin
          new_hi   <= 1'b0;
        end
      end else if (state == RUN) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (saturated || ovf) begin
          score     <= ALL_NINE;
          saturated <= 1'b1;
        end else begin
          score <= sum_x[W-1:0];
        end
      end
      if (clear_hi && (state != RUN)) begin
        hi_score <= '0;
        new_hi   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_score_keeper_bcd.sv
// tb_score_keeper_bcd: randomized and directed checks of
// score_keeper_bcd (4-digit and 2-digit) against an integer model.
module tb_score_keeper_bcd;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       gameover = 1'b0;
  logic       add_valid = 1'b0;
  logic [3:0] add_value = 4'd0;
  logic       clear_hi = 1'b0;

  logic [15:0] score4, hi4;
  logic        run4, nh4, sat4;
  logic [7:0]  score2, hi2;
  logic        run2, nh2, sat2;

  int errors = 0;
  int checks = 0;

  // model: 0 idle, 1 run, 2 over
  int m_state;
  int m_k;
  int m_score[2];
  int m_hi[2];
  bit m_newhi[2];
  bit m_sat[2];
  int caps[2] = '{9999, 99};

  always #5 clk = ~clk;

  score_keeper_bcd #(
    .NUM_DIGITS(4), .TICK_DIV(100), .SIMULATE(1'b1)
  ) u4 (
    .clk(clk), .reset(reset), .start(start),
    .gameover(gameover), .add_valid(add_valid),
    .add_value(add_value), .clear_hi(clear_hi),
    .score(score4), .hi_score(hi4), .running(run4),
    .new_hi(nh4), .saturated(sat4)
  );

  score_keeper_bcd #(
    .NUM_DIGITS(2), .TICK_DIV(100), .SIMULATE(1'b1)
  ) u2 (
    .clk(clk), .reset(reset), .start(start),
    .gameover(gameover), .add_valid(add_valid),
    .add_value(add_value), .clear_hi(clear_hi),
    .score(score2), .hi_score(hi2), .running(run2),
    .new_hi(nh2), .saturated(sat2)
  );

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_k = 0;
    for (int j = 0; j < 2; j++) begin
      m_score[j] = 0;
      m_hi[j] = 0;
      m_newhi[j] = 1'b0;
      m_sat[j] = 1'b0;
    end
  endtask

  task automatic step(input bit st, input bit go, input bit av,
                      input logic [3:0] val, input bit clr);
    int inc;
    bit tk;
    start = st;
    gameover = go;
    add_valid = av;
    add_value = val;
    clear_hi = clr;
    @(posedge clk);
    if (m_state == 1) begin
      if (go) begin
        for (int j = 0; j < 2; j++) begin
          if (m_score[j] > m_hi[j]) begin
            m_hi[j] = m_score[j];
            m_newhi[j] = 1'b1;
          end else begin
            m_newhi[j] = 1'b0;
          end
        end
        m_state = 2;
      end else begin
        tk = (m_k % 10) == 9;
        inc = (tk ? 1 : 0) + (av ? ((int'(val) > 9) ? 9 : int'(val)) : 0);
        for (int j = 0; j < 2; j++) begin
          if (m_score[j] + inc > caps[j]) begin
            m_score[j] = caps[j];
            m_sat[j] = 1'b1;
          end else begin
            m_score[j] = m_score[j] + inc;
          end
        end
        m_k++;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (clr) begin
          m_hi[j] = 0;
          m_newhi[j] = 1'b0;
        end
        if (st) begin
          m_score[j] = 0;
          m_sat[j] = 1'b0;
          m_newhi[j] = 1'b0;
        end
      end
      if (st) begin
        m_state = 1;
        m_k = 0;
      end
    end
    #1;
    start = 1'b0;
    gameover = 1'b0;
    add_valid = 1'b0;
    add_value = 4'd0;
    clear_hi = 1'b0;
  endtask

  // Greedy event adds aimed at a target score for model idx.
  task automatic drive_to(input int target, input int idx, input int n);
    int need;
    int t;
    for (int c = 0; c < n; c++) begin
      t = ((m_k % 10) == 9) ? 1 : 0;
      need = target - m_score[idx] - t;
      if (need > 9) need = 9;
      if (need < 0) need = 0;
      step(1'b0, 1'b0, need > 0, 4'(need), 1'b0);
    end
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({score4, hi4, run4, nh4, sat4} !== 35'd0) begin
      errors++;
      $display("FAIL reset4 got %h/%h %b%b%b want 0", score4, hi4, run4, nh4, sat4);
    end
    checks++;
    if ({score2, hi2, run2, nh2, sat2} !== 19'd0) begin
      errors++;
      $display("FAIL reset2 got %h/%h %b%b%b want 0", score2, hi2, run2, nh2, sat2);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_tick();
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 35; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    checks++;
    if (score4 !== 16'h0003 || run4 !== 1'b1) begin
      errors++;
      $display("FAIL tick_count got %h run=%b want 0003 run=1", score4, run4);
    end
  endtask

  task automatic test_add();
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'd5, 1'b0);
    checks++;
    if (score4 !== 16'h0005) begin
      errors++;
      $display("FAIL add5 got %h want 0005", score4);
    end
    step(1'b0, 1'b0, 1'b1, 4'd7, 1'b0);
    checks++;
    if (score4 !== 16'h0012) begin
      errors++;
      $display("FAIL add7_carry got %h want 0012", score4);
    end
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    drive_to(91, 0, 19);
    checks++;
    if (score4 !== 16'h0091) begin
      errors++;
      $display("FAIL pre_tick got %h want 0091", score4);
    end
    step(1'b0, 1'b0, 1'b1, 4'd9, 1'b0);
    checks++;
    if (score4 !== 16'h0101) begin
      errors++;
      $display("FAIL tick_plus9 got %h want 0101", score4);
    end
    step(1'b0, 1'b0, 1'b1, 4'd15, 1'b0);
    checks++;
    if (score4 !== 16'h0110) begin
      errors++;
      $display("FAIL clamp15 got %h want 0110", score4);
    end
  endtask

  task automatic test_saturate();
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    drive_to(97, 1, 12);
    checks++;
    if (score2 !== 8'h97 || sat2 !== 1'b0) begin
      errors++;
      $display("FAIL sat_pre got %h sat=%b want 97 sat=0", score2, sat2);
    end
    step(1'b0, 1'b0, 1'b1, 4'd5, 1'b0);
    checks++;
    if (score2 !== 8'h99 || sat2 !== 1'b1) begin
      errors++;
      $display("FAIL sat_hit got %h sat=%b want 99 sat=1", score2, sat2);
    end
    step(1'b0, 1'b0, 1'b1, 4'd3, 1'b0);
    checks++;
    if (score2 !== 8'h99 || sat2 !== 1'b1) begin
      errors++;
      $display("FAIL sat_hold got %h sat=%b want 99 sat=1", score2, sat2);
    end
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    checks++;
    if (score2 !== 8'h00 || sat2 !== 1'b0) begin
      errors++;
      $display("FAIL sat_clear got %h sat=%b want 00 sat=0", score2, sat2);
    end
  endtask

  task automatic test_hi_score();
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    checks++;
    if (hi4 !== 16'h0000 || nh4 !== 1'b0) begin
      errors++;
      $display("FAIL clear_hi got %h nh=%b want 0000 nh=0", hi4, nh4);
    end
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    drive_to(42, 0, 8);
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    checks++;
    if (hi4 !== 16'h0042 || nh4 !== 1'b1) begin
      errors++;
      $display("FAIL game1 got %h nh=%b want 0042 nh=1", hi4, nh4);
    end
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    drive_to(42, 0, 8);
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    checks++;
    if (hi4 !== 16'h0042 || nh4 !== 1'b0) begin
      errors++;
      $display("FAIL game2_tie got %h nh=%b want 0042 nh=0", hi4, nh4);
    end
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    drive_to(100, 0, 14);
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    checks++;
    if (hi4 !== 16'h0100 || nh4 !== 1'b1) begin
      errors++;
      $display("FAIL game3 got %h nh=%b want 0100 nh=1", hi4, nh4);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    drive_to(20, 0, 5);
    step(1'b0, 1'b1, 1'b1, 4'd9, 1'b0);
    checks++;
    if (score4 !== 16'h0020 || run4 !== 1'b0) begin
      errors++;
      $display("FAIL go_discard got %h run=%b want 0020 run=0", score4, run4);
    end
    step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    checks++;
    if (score4 !== 16'h0000 || run4 !== 1'b1) begin
      errors++;
      $display("FAIL start_wins got %h run=%b want 0000 run=1", score4, run4);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    checks++;
    if (hi4 !== 16'h0100) begin
      errors++;
      $display("FAIL clear_in_run got %h want 0100", hi4);
    end
    drive_to(30, 0, 5);
    #2 reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({score4, hi4, run4, nh4, sat4} !== 35'd0) begin
      errors++;
      $display("FAIL async_reset got %h/%h %b%b%b want 0", score4, hi4, run4, nh4, sat4);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (run4 !== 1'b0 || score4 !== 16'h0000) begin
      errors++;
      $display("FAIL idle_after_reset got run=%b %h want run=0 0000", run4, score4);
    end
  endtask

  task automatic test_random();
    logic [31:0] e0, e1, eh0, eh1;
    bit st, go, av, clr;
    logic [3:0] val;
    for (int i = 0; i < 400; i++) begin
      st  = ($urandom_range(0, 19) == 0);
      go  = ($urandom_range(0, 39) == 0);
      av  = ($urandom_range(0, 1) == 1);
      clr = ($urandom_range(0, 29) == 0);
      val = 4'($urandom_range(0, 15));
      step(st, go, av, val, clr);
      e0 = to_bcd(m_score[0]);
      eh0 = to_bcd(m_hi[0]);
      e1 = to_bcd(m_score[1]);
      eh1 = to_bcd(m_hi[1]);
      checks++;
      if ({score4, hi4, run4, nh4, sat4} !==
          {e0[15:0], eh0[15:0], m_state == 1, m_newhi[0], m_sat[0]}) begin
        errors++;
        $display("FAIL rand4 cyc %0d got %h/%h %b%b%b want %h/%h %b%b%b", i,
                 score4, hi4, run4, nh4, sat4, e0[15:0], eh0[15:0],
                 m_state == 1, m_newhi[0], m_sat[0]);
      end
      checks++;
      if ({score2, hi2, run2, nh2, sat2} !==
          {e1[7:0], eh1[7:0], m_state == 1, m_newhi[1], m_sat[1]}) begin
        errors++;
        $display("FAIL rand2 cyc %0d got %h/%h %b%b%b want %h/%h %b%b%b", i,
                 score2, hi2, run2, nh2, sat2, e1[7:0], eh1[7:0],
                 m_state == 1, m_newhi[1], m_sat[1]);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_tick();
    test_add();
    test_saturate();
    test_hi_score();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
